// File: rtl/loop_down_counter_if.sv
// Handshake/status bundle between a loop controller (master) and loop_down_counter (slave).
interface loop_down_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             enable;
    logic             abort;
    logic             start_ready;
    logic [WIDTH-1:0] count_out;
    logic             busy;
    logic             done;

    modport master (
        output start, load_val, enable, abort,
        input  start_ready, count_out, busy, done
    );

    modport slave (
        input  start, load_val, enable, abort,
        output start_ready, count_out, busy, done
    );
endinterface

// File: rtl/loop_down_counter.sv
// Loadable loop-bound down-counter with start handshake and single-cycle done pulse.
// Optional macro LOOP_DOWN_COUNTER_AUTORELOAD_EN: reload from the latched count at terminal count.
module loop_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    loop_down_counter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             busy_q;
    logic             done_q;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
    // The latched iteration count is only observable when reloading.
    logic [WIDTH-1:0] load_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
            load_q  <= '0;
`endif
        end else if (bus.abort) begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        count_q <= bus.load_val;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
                        load_q  <= bus.load_val;
`endif
                        // A zero-length loop finishes immediately without entering RUN.
                        if (bus.load_val == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (bus.enable) begin
                        if (count_q == CountOne) begin
                            done_q <= 1'b1;
`ifdef LOOP_DOWN_COUNTER_AUTORELOAD_EN
                            count_q <= load_q;
`else
                            count_q <= '0;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            count_q <= count_q - CountOne;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.start_ready = !rst && !bus.abort && (state_q == StIdle);
    assign bus.count_out   = count_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_loop_down_counter.sv
// Self-checking bench for loop_down_counter: vector table plus a randomly gapped full-range run.
module tb_loop_down_counter;

    localparam int unsigned WIDTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    loop_down_counter_if #(.WIDTH(WIDTH)) bus ();

    loop_down_counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic             rst;
        logic             start;
        logic [WIDTH-1:0] load_val;
        logic             enable;
        logic             abort;
        logic             exp_ready;  // start_ready during the cycle the inputs are applied
        logic [WIDTH-1:0] exp_count;  // outputs after the following edge
        logic             exp_busy;
        logic             exp_done;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             done;
        int               idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic s, input int lv, input logic en,
                       input logic ab, input logic rdy, input int cnt, input logic b,
                       input logic d);
        vec_t v;
        v.rst       = r;
        v.start     = s;
        v.load_val  = WIDTH'(lv);
        v.enable    = en;
        v.abort     = ab;
        v.exp_ready = rdy;
        v.exp_count = WIDTH'(cnt);
        v.exp_busy  = b;
        v.exp_done  = d;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input int lv, input logic en,
                         input logic ab);
        rst          = r;
        bus.start    = s;
        bus.load_val = WIDTH'(lv);
        bus.enable   = en;
        bus.abort    = ab;
    endtask

    int   steps;
    logic got_done;
    logic en_bit;

    initial begin
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);

        //   rst  st  lv  en  ab  rdy  cnt bsy don
        add(1, 1, 5, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);   // enable ignored in idle
`ifndef LOOP_DOWN_COUNTER_AUTORELOAD_EN
        // basic count of 5
        add(0, 1, 5, 0, 0, 1, 5, 1, 0);
        add(0, 0, 0, 1, 0, 0, 4, 1, 0);
        add(0, 0, 0, 1, 0, 0, 3, 1, 0);
        add(0, 0, 0, 1, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // back-to-back start of 3, gapped enable 1,0,0,1,0,1
        add(0, 1, 3, 0, 0, 1, 3, 1, 0);
        add(0, 0, 0, 1, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // zero-length, then load 2 in the done cycle
        add(0, 1, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 2, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1);   // zero-length during done re-pulses
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // ignored start in RUN, then abort
        add(0, 1, 15, 0, 0, 1, 15, 1, 0);
        add(0, 0, 0, 1, 0, 0, 14, 1, 0);
        add(0, 0, 0, 1, 0, 0, 13, 1, 0);
        add(0, 0, 0, 1, 0, 0, 12, 1, 0);
        add(0, 0, 0, 1, 0, 0, 11, 1, 0);
        add(0, 1, 3, 0, 0, 0, 11, 1, 0);
        add(0, 1, 3, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // abort blocks a start in idle
        add(0, 1, 7, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // reset mid-run
        add(0, 1, 4, 0, 0, 1, 4, 1, 0);
        add(0, 0, 0, 1, 0, 0, 3, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // abort on the terminal step suppresses done
        add(0, 1, 1, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
`else
        // autoreload: 3,2,1,3,2,1,3,2,1 with done at each reload
        add(0, 1, 3, 0, 0, 1, 3, 1, 0);
        add(0, 0, 0, 1, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 1, 5, 1, 0, 0, 3, 1, 1);
        add(0, 0, 0, 1, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 3, 1, 1);
        add(0, 0, 0, 1, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 3, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            drive(vecs[i].rst, vecs[i].start, int'(vecs[i].load_val), vecs[i].enable,
                  vecs[i].abort);
            #1;
            check("start_ready", i, int'(bus.start_ready), int'(vecs[i].exp_ready));
            e.count = vecs[i].exp_count;
            e.busy  = vecs[i].exp_busy;
            e.done  = vecs[i].exp_done;
            e.idx   = i;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard step %0d: got empty queue, want one entry", i);
            end else begin
                e = sb_q.pop_front();
                check("count_out", e.idx, int'(bus.count_out), int'(e.count));
                check("busy", e.idx, int'(bus.busy), int'(e.busy));
                check("done", e.idx, int'(bus.done), int'(e.done));
            end
        end

        // Full-range run with random enable gaps: exactly 15 enabled steps to done.
        drive(1'b0, 1'b1, 15, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", 0, int'(bus.busy), 1);
        steps    = 0;
        got_done = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            en_bit     = 1'($urandom_range(0, 1));
            bus.enable = en_bit;
            @(posedge clk);
            #1;
            if (en_bit) steps++;
            if (bus.done) got_done = 1'b1;
        end
        check("gapped_done_seen", 0, int'(got_done), 1);
        check("gapped_steps", 0, steps, 15);
`ifndef LOOP_DOWN_COUNTER_AUTORELOAD_EN
        check("gapped_final_count", 0, int'(bus.count_out), 0);
        check("gapped_final_busy", 0, int'(bus.busy), 0);
`else
        check("gapped_final_count", 0, int'(bus.count_out), 15);
        check("gapped_final_busy", 0, int'(bus.busy), 1);
`endif
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("done_single_cycle", 0, int'(bus.done), 0);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        #1;
        check("idle_after_abort", 0, int'(bus.start_ready), 1);
        check("busy_after_abort", 0, int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
